scoreboard_scalar: RTL and testbench
====================================

# scoreboard_scalar

Per-issue-slice register scoreboard for the scalar pipeline. It sits directly downstream of one scalar instruction-buffer output slice and upstream of operand fetch/dispatch; one instance exists per issue slice. It holds an instruction at the head of its buffer until none of its registers is pending a writeback. It then forwards the instruction through a one-entry output register and marks its destination register pending until the matching writeback releases it.

## Interface
Parameters:
- `WIS_CNT`, default 1: warps per issue slice (`WARP_CNT / ISSUE_CNT`).
- `WIS_W`, default `LOG2UP(WIS_CNT)`: width of the warp-in-slice index.
- `NR_BITS`, default 6: register index width. Register space is `2**NR_BITS`. Index 0 is hardwired zero.
- `DATAW`, default 128: width of the opaque instruction payload (uuid, tmask, op fields, PC, imm).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `in_valid` in 1: instruction-buffer head valid.
- `in_ready` out 1: head accepted this cycle.
- `in_wis` in WIS_W: warp-in-slice index of the head.
- `in_wb` in 1: instruction writes `in_rd`.
- `in_rd`, `in_rs1`, `in_rs2`, `in_rs3` in NR_BITS each: register indices. Unused sources are 0.
- `in_data` in DATAW: payload, passed through untouched.
- `out_valid` out 1: instruction available to dispatch.
- `out_ready` in 1: dispatch accepts.
- `out_wis`, `out_wb`, `out_rd`, `out_rs1..3`, `out_data` out: registered copies of the accepted fields.
- `wb_valid` in 1: writeback event.
- `wb_wis` in WIS_W: warp of the writeback.
- `wb_rd` in NR_BITS: register being written.
- `wb_eop` in 1: last packet of this writeback. Release happens only when set.
- `perf_stalls` out 32: count of cycles in which the head was blocked by a hazard.

## Operation
- State:
  - `pending[WIS_CNT][2**NR_BITS]` bit array.
  - Output register (`out_valid` plus fields).
  - `perf_stalls` counter.
- Release: `release = wb_valid && wb_eop && wb_rd != 0`. It clears `pending[wb_wis][wb_rd]`.
- Release bypass: hazard checks use the pending view after this cycle's release (`pending & ~release_mask`). An instruction that depends on a register being released issues in the same cycle.
- Hazard: `in_valid` and any of `rs1`, `rs2`, `rs3` (nonzero) is pending for `in_wis`, or (`in_wb` and `rd != 0` and `rd` pending). Register 0 never causes a hazard.
- Space: `space = !out_valid || out_ready`.
- `in_ready = !hazard && space`. `in_ready` does not depend on `in_valid`; with `in_valid` low, hazard is false and `in_ready = space`.
- Fire: `fire_in = in_valid && in_ready`. On fire, load the output register with all fields and set `out_valid`.
- Output drain: `out_valid` clears on `out_valid && out_ready` without a simultaneous `fire_in`.
- Set: on `fire_in && in_wb && in_rd != 0`, set `pending[in_wis][in_rd]` in the same edge.
- Same-entry set and release: set wins. This case is only reachable through the release bypass, because WAW on a still-pending `rd` is blocked.
- Writeback to a non-pending register: no effect, no error.
- `perf_stalls` increments when `in_valid && hazard` and saturates at all-ones.

## Timing
- Reset values:
  - `out_valid` = 0.
  - All `pending` = 0.
  - `perf_stalls` = 0.
  - Output fields = 0.
  - `in_ready` reflects `space` = 1 while no hazard.
- Latency: input fire at edge N, so `out_valid` is high from cycle N+1. Full throughput is one instruction per cycle when `out_ready` is held high.
- A pending bit set at edge N blocks dependents from cycle N+1.
- A release in cycle N unblocks dependents in cycle N (bypass).
- Output fields are stable while `out_valid && !out_ready`.
- Reset mid-operation drops the buffered instruction and all pending bits. Writebacks arriving while `reset` is high are ignored.

## Test plan
- Independent stream: `in_valid` held 1, `rd` = 1..8 in sequence, all `rs` = 0, `out_ready` = 1 → 8 outputs on consecutive cycles, first output one cycle after first fire; `perf_stalls` = 0.
- RAW stall: issue wis 0 `rd`=5 `wb`=1, then `rs1`=5 → second instruction blocked. Hold 10 cycles, then `wb_valid`/`wb_eop` for `wb_rd`=5 → second instruction fires in the same cycle as the writeback; `perf_stalls` = 10.
- Multi-packet and warp isolation: `rd`=7 pending for wis 0. A writeback with `wb_eop`=0 does not release. wis 1 reading r7 issues immediately. A wis 0 `wb_eop`=1 writeback releases.
- Register 0 and WAW: instruction with `rd`=0 `wb`=1 sets nothing and a following `rs1`=0 reader is not blocked. A second write to a pending `rd`=3 stalls until r3 is released.
- Backpressure: `out_ready`=0 for 5 cycles with 2 queued independent instructions → first held stable, `in_ready`=0, no loss or duplication after `out_ready` rises.
- Reset mid-run: r4 pending and `out_valid`=1, pulse `reset` → `out_valid`=0, a reader of r4 issues immediately, `perf_stalls`=0.

Source files
------------

// File: rtl/scoreboard_scalar.sv
// Per-issue-slice register scoreboard: holds the buffer head until its registers are free,
// forwards it through a one-entry output register and tracks destination registers in flight.
module scoreboard_scalar #(
  parameter int unsigned WIS_CNT = 1,
  parameter int unsigned WIS_W   = (WIS_CNT > 1) ? $clog2(WIS_CNT) : 1,
  parameter int unsigned NR_BITS = 6,
  parameter int unsigned DATAW   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIS_W-1:0]   in_wis,
  input  logic               in_wb,
  input  logic [NR_BITS-1:0] in_rd,
  input  logic [NR_BITS-1:0] in_rs1,
  input  logic [NR_BITS-1:0] in_rs2,
  input  logic [NR_BITS-1:0] in_rs3,
  input  logic [DATAW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIS_W-1:0]   out_wis,
  output logic               out_wb,
  output logic [NR_BITS-1:0] out_rd,
  output logic [NR_BITS-1:0] out_rs1,
  output logic [NR_BITS-1:0] out_rs2,
  output logic [NR_BITS-1:0] out_rs3,
  output logic [DATAW-1:0]   out_data,
  input  logic               wb_valid,
  input  logic [WIS_W-1:0]   wb_wis,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop,
  output logic [31:0]        perf_stalls
);

  localparam int unsigned NREGS = 2 ** NR_BITS;

  logic [NREGS-1:0]   r_pending [WIS_CNT];
  logic               r_out_valid;
  logic [WIS_W-1:0]   r_out_wis;
  logic               r_out_wb;
  logic [NR_BITS-1:0] r_out_rd;
  logic [NR_BITS-1:0] r_out_rs1;
  logic [NR_BITS-1:0] r_out_rs2;
  logic [NR_BITS-1:0] r_out_rs3;
  logic [DATAW-1:0]   r_out_data;
  logic [31:0]        r_perf;

  logic               w_release;
  logic               w_set;
  logic [NREGS-1:0]   w_pend_sel;
  logic [NREGS-1:0]   w_rel_mask;
  logic [NREGS-1:0]   w_view;
  logic               w_hazard;
  logic               w_space;
  logic               w_fire;

  assign w_release = wb_valid && wb_eop && (wb_rd != '0);

  always_comb begin
    w_pend_sel = '0;
    for (int w = 0; w < int'(WIS_CNT); w++) begin
      if (in_wis == WIS_W'(w)) w_pend_sel = r_pending[w];
    end
  end

  // Same-cycle release is bypassed so a dependent can issue alongside its writeback.
  assign w_rel_mask = (w_release && (wb_wis == in_wis)) ? (NREGS'(1) << wb_rd) : '0;
  assign w_view     = w_pend_sel & ~w_rel_mask;

  assign w_hazard = in_valid &&
                    (((in_rs1 != '0) && w_view[in_rs1]) ||
                     ((in_rs2 != '0) && w_view[in_rs2]) ||
                     ((in_rs3 != '0) && w_view[in_rs3]) ||
                     (in_wb && (in_rd != '0) && w_view[in_rd]));

  assign w_space  = !r_out_valid || out_ready;
  assign in_ready = !w_hazard && w_space;
  assign w_fire   = in_valid && in_ready;
  assign w_set    = w_fire && in_wb && (in_rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < int'(WIS_CNT); w++) r_pending[w] <= '0;
    end else begin
      // The set comes after the release, so a same-entry collision leaves the bit set.
      for (int w = 0; w < int'(WIS_CNT); w++) begin
        if (w_release && (wb_wis == WIS_W'(w))) r_pending[w][wb_rd] <= 1'b0;
        if (w_set && (in_wis == WIS_W'(w)))     r_pending[w][in_rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_wis   <= '0;
      r_out_wb    <= 1'b0;
      r_out_rd    <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rs3   <= '0;
      r_out_data  <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_wis   <= in_wis;
      r_out_wb    <= in_wb;
      r_out_rd    <= in_rd;
      r_out_rs1   <= in_rs1;
      r_out_rs2   <= in_rs2;
      r_out_rs3   <= in_rs3;
      r_out_data  <= in_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_hazard && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_wis     = r_out_wis;
  assign out_wb      = r_out_wb;
  assign out_rd      = r_out_rd;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_rs3     = r_out_rs3;
  assign out_data    = r_out_data;
  assign perf_stalls = r_perf;

endmodule

// File: tb/tb_scoreboard_scalar.sv
// Directed bench for scoreboard_scalar: stream, RAW/WAW stalls, writeback bypass,
// warp isolation, backpressure and mid-run reset.
module tb_scoreboard_scalar;

  localparam int unsigned WIS_CNT = 2;
  localparam int unsigned WIS_W   = 1;
  localparam int unsigned NR_BITS = 6;
  localparam int unsigned DATAW   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIS_W-1:0]   in_wis;
  logic               in_wb;
  logic [NR_BITS-1:0] in_rd, in_rs1, in_rs2, in_rs3;
  logic [DATAW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIS_W-1:0]   out_wis;
  logic               out_wb;
  logic [NR_BITS-1:0] out_rd, out_rs1, out_rs2, out_rs3;
  logic [DATAW-1:0]   out_data;
  logic               wb_valid;
  logic [WIS_W-1:0]   wb_wis;
  logic [NR_BITS-1:0] wb_rd;
  logic               wb_eop;
  logic [31:0]        perf_stalls;

  int n_vec = 0;
  int n_err = 0;

  scoreboard_scalar #(
    .WIS_CNT (WIS_CNT),
    .WIS_W   (WIS_W),
    .NR_BITS (NR_BITS),
    .DATAW   (DATAW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wis      (in_wis),
    .in_wb       (in_wb),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs3      (in_rs3),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wis     (out_wis),
    .out_wb      (out_wb),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rs3     (out_rs3),
    .out_data    (out_data),
    .wb_valid    (wb_valid),
    .wb_wis      (wb_wis),
    .wb_rd       (wb_rd),
    .wb_eop      (wb_eop),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are checked 1 ns after the edge; inputs change there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [WIS_W-1:0] wis, input logic wb,
                        input logic [NR_BITS-1:0] rd, input logic [NR_BITS-1:0] rs1,
                        input logic [DATAW-1:0] data);
    in_valid = v;
    in_wis   = wis;
    in_wb    = wb;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = '0;
    in_rs3   = '0;
    in_data  = data;
  endtask

  task automatic set_wb(input logic v, input logic [WIS_W-1:0] wis,
                        input logic [NR_BITS-1:0] rd, input logic eop);
    wb_valid = v;
    wb_wis   = wis;
    wb_rd    = rd;
    wb_eop   = eop;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_perf", 64'(perf_stalls), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Independent stream: rd 1..8, one output per cycle.
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 6'(i), 6'd0, 16'(i + 16'h100));
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      cyc();
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_out_rd", 64'(out_rd), 64'(i));
      chk("stream_out_data", 64'(out_data), 64'(i + 16'h100));
    end
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    cyc();
    chk("stream_drain", 64'(out_valid), 64'd0);
    chk("stream_perf", 64'(perf_stalls), 64'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // RAW stall for 10 cycles, released by a bypassed writeback.
    set_in(1'b1, 1'b0, 1'b1, 6'd5, 6'd0, 16'h0055);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd5, 16'h00AA);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("raw_blocked", 64'(in_ready), 64'd0);
      cyc();
    end
    set_wb(1'b1, 1'b0, 6'd5, 1'b1);
    #1;
    chk("raw_bypass_ready", 64'(in_ready), 64'd1);
    cyc();
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("raw_out_valid", 64'(out_valid), 64'd1);
    chk("raw_out_rs1", 64'(out_rs1), 64'd5);
    chk("raw_out_data", 64'(out_data), 64'h00AA);
    chk("raw_perf", 64'(perf_stalls), 64'd10);

    // Multi-packet writeback and warp isolation on r7.
    set_in(1'b1, 1'b0, 1'b1, 6'd7, 6'd0, 16'h0077);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd7, 16'h0701);
    set_wb(1'b1, 1'b0, 6'd7, 1'b0);
    #1;
    chk("mp_no_eop_blocked", 64'(in_ready), 64'd0);
    cyc();
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 6'd7, 16'h0711);
    #1;
    chk("mp_other_warp_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("mp_other_warp_wis", 64'(out_wis), 64'd1);
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd7, 16'h0702);
    set_wb(1'b1, 1'b1, 6'd7, 1'b1);
    #1;
    chk("mp_wrong_warp_wb", 64'(in_ready), 64'd0);
    cyc();
    set_wb(1'b1, 1'b0, 6'd7, 1'b1);
    #1;
    chk("mp_eop_release", 64'(in_ready), 64'd1);
    cyc();
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    chk("mp_out_wis", 64'(out_wis), 64'd0);
    chk("mp_out_data", 64'(out_data), 64'h0702);
    #1;
    chk("mp_r7_cleared", 64'(in_ready), 64'd1);
    cyc();
    chk("mp_perf", 64'(perf_stalls), 64'd12);

    // Register 0 never pends; WAW on r3 stalls; same-entry set and release keeps r3 pending.
    set_in(1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 16'h0000);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0001);
    #1;
    chk("r0_reader_ready", 64'(in_ready), 64'd1);
    cyc();
    set_in(1'b1, 1'b0, 1'b1, 6'd3, 6'd0, 16'h0031);
    #1;
    chk("waw_first_ready", 64'(in_ready), 64'd1);
    cyc();
    set_in(1'b1, 1'b0, 1'b1, 6'd3, 6'd0, 16'h0032);
    #1;
    chk("waw_blocked_a", 64'(in_ready), 64'd0);
    cyc();
    chk("waw_blocked_b", 64'(in_ready), 64'd0);
    cyc();
    set_wb(1'b1, 1'b0, 6'd3, 1'b1);
    #1;
    chk("waw_bypass_ready", 64'(in_ready), 64'd1);
    cyc();
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    chk("waw_out_data", 64'(out_data), 64'h0032);
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd3, 16'h0033);
    #1;
    chk("set_wins_blocked", 64'(in_ready), 64'd0);
    cyc();
    set_wb(1'b1, 1'b0, 6'd3, 1'b1);
    #1;
    chk("set_wins_release", 64'(in_ready), 64'd1);
    cyc();
    set_wb(1'b0, 1'b0, 6'd0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("waw_perf", 64'(perf_stalls), 64'd15);
    cyc();
    chk("waw_drain", 64'(out_valid), 64'd0);

    // Backpressure: first instruction held stable, second waits, neither lost nor duplicated.
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0011);
    #1;
    chk("bp_first_ready", 64'(in_ready), 64'd1);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0022);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'h0011);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_data", 64'(out_data), 64'h0022);
    cyc();
    chk("bp_no_dup", 64'(out_valid), 64'd0);
    chk("bp_perf", 64'(perf_stalls), 64'd15);

    // Reset mid-run drops the buffered instruction and r4's pending bit.
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 6'd4, 6'd0, 16'h0044);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("mr_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    out_ready = 1'b1;
    chk("mr_out_valid_clr", 64'(out_valid), 64'd0);
    chk("mr_perf_clr", 64'(perf_stalls), 64'd0);
    chk("mr_out_data_clr", 64'(out_data), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd4, 16'h0045);
    #1;
    chk("mr_r4_ready", 64'(in_ready), 64'd1);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("mr_out_rs1", 64'(out_rs1), 64'd4);
    chk("mr_out_data", 64'(out_data), 64'h0045);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
